// File: rtl/tdm_demux_if.sv
// TDM link bundle: serial beat inputs plus the deserialized frame outputs.
interface tdm_demux_if #(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int CNT_W = 8
);
    logic              in_valid;
    logic              in_sof;
    logic [W-1:0]      in_data;
    logic [N_CH*W-1:0] out_data;
    logic              out_valid;
    logic              sync_err;
    logic [CNT_W-1:0]  frame_cnt;

    modport slave (
        input  in_valid, in_sof, in_data,
        output out_data, out_valid, sync_err, frame_cnt
    );

    modport master (
        output in_valid, in_sof, in_data,
        input  out_data, out_valid, sync_err, frame_cnt
    );
endinterface

// File: rtl/tdm_demux.sv
// TDM receive deserializer: slots beats into a capture buffer, publishes whole
// frames atomically, flags framing errors and counts good frames.
module tdm_demux #(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    tdm_demux_if.slave  bus
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    typedef enum logic {HUNT, COLLECT} state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [N_CH-1:0][W-1:0]   cap_q, cap_d;
    logic [N_CH*W-1:0]        out_q, out_d;
    logic                     ov_q, ov_d;
    logic                     err_q, err_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     last_beat;

    assign last_beat = bus.in_valid && !bus.in_sof && (state_q == COLLECT) &&
                       (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            idx_q   <= '0;
            cap_q   <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.in_valid) begin
            case (state_q)
                HUNT:    if (bus.in_sof) state_d = COLLECT;
                COLLECT: if (last_beat)  state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    // Pulses default low so they last exactly one cycle per event.
    always_comb begin
        idx_d = idx_q;
        cap_d = cap_q;
        out_d = out_q;
        ov_d  = 1'b0;
        err_d = 1'b0;
        cnt_d = cnt_q;
        if (bus.in_valid) begin
            if (bus.in_sof) begin
                // SOF always restarts a frame; in COLLECT it also means the old one was short.
                cap_d[0] = bus.in_data;
                idx_d    = IDX_W'(1);
                err_d    = (state_q == COLLECT);
            end else if (state_q == HUNT) begin
                err_d = 1'b1;
            end else begin
                cap_d[idx_q] = bus.in_data;
                if (last_beat) begin
                    out_d = cap_d;
                    ov_d  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end
    end

    assign bus.out_data  = out_q;
    assign bus.out_valid = ov_q;
    assign bus.sync_err  = err_q;
    assign bus.frame_cnt = cnt_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: stimulus queues expected pulses, a negedge
// monitor pops and compares each out_valid / sync_err event.
module tb_tdm_demux;
    localparam int NONE = 0, FRM = 1, ERR = 2;

    typedef struct {
        bit          err;
        logic [31:0] data;
        logic [7:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t q[$];
    int   ov_cyc[$];

    tdm_demux_if #(.N_CH(4), .W(8), .CNT_W(8)) bus ();

    tdm_demux #(.N_CH(4), .W(8), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.out_valid && bus.sync_err) begin
                n_cmp++; n_bad++;
                $display("FAIL overlap: out_valid and sync_err both 1 at cycle %0d", cyc);
            end
            if (bus.out_valid) begin
                ov_cyc.push_back(cyc);
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_out_valid: got pulse at cycle %0d expected none", cyc);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", {63'd0, 1'b0}, {63'd0, e.err});
                    chk("out_data", {32'd0, bus.out_data}, {32'd0, e.data});
                    chk("frame_cnt", {56'd0, bus.frame_cnt}, {56'd0, e.cnt});
                end
            end
            if (bus.sync_err) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_sync_err: got pulse at cycle %0d expected none", cyc);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", {63'd0, 1'b1}, {63'd0, e.err});
                end
            end
        end
    end

    // Drive one valid beat; the expected event is queued after the sampling edge.
    task automatic beat(input bit sof, input logic [7:0] d, input int kind,
                        input logic [31:0] ed, input logic [7:0] ec);
        exp_t e;
        bus.in_valid = 1'b1; bus.in_sof = sof; bus.in_data = d;
        @(posedge clk);
        if (kind == FRM) begin
            e.err = 1'b0; e.data = ed; e.cnt = ec; q.push_back(e);
        end else if (kind == ERR) begin
            e.err = 1'b1; e.data = '0; e.cnt = '0; q.push_back(e);
        end
        #1;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        idle(3);
        chk({name, "_pending"}, 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0;
        rst_n = 1'b0;
        #2;
        chk("rst_out_data", {32'd0, bus.out_data}, 64'd0);
        chk("rst_frame_cnt", {56'd0, bus.frame_cnt}, 64'd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_sync_err", {63'd0, bus.sync_err}, 64'd0);
        q.delete();
        ov_cyc.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] b0, b1, b2, b3;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0;
        #1;

        // 1: basic frame
        do_reset();
        beat(1, 8'h11, NONE, 0, 0);
        beat(0, 8'h22, NONE, 0, 0);
        beat(0, 8'h33, NONE, 0, 0);
        beat(0, 8'h44, FRM, 32'h44332211, 8'd1);
        drain("t1");
        chk("t1_ov_count", 64'(ov_cyc.size()), 64'd1);

        // 2: gaps between beats
        do_reset();
        beat(1, 8'h11, NONE, 0, 0); idle(3);
        beat(0, 8'h22, NONE, 0, 0); idle(3);
        beat(0, 8'h33, NONE, 0, 0); idle(3);
        beat(0, 8'h44, FRM, 32'h44332211, 8'd1);
        drain("t2");
        chk("t2_hold_data", {32'd0, bus.out_data}, 64'h44332211);

        // 3: early SOF
        do_reset();
        beat(1, 8'hA1, NONE, 0, 0);
        beat(0, 8'hA2, NONE, 0, 0);
        beat(1, 8'hB1, ERR, 0, 0);
        beat(0, 8'hB2, NONE, 0, 0);
        beat(0, 8'hB3, NONE, 0, 0);
        beat(0, 8'hB4, FRM, 32'hB4B3B2B1, 8'd1);
        drain("t3");

        // 4: beats while hunting
        do_reset();
        beat(0, 8'h77, ERR, 0, 0);
        beat(0, 8'h78, ERR, 0, 0);
        beat(1, 8'h01, NONE, 0, 0);
        beat(0, 8'h02, NONE, 0, 0);
        beat(0, 8'h03, NONE, 0, 0);
        beat(0, 8'h04, FRM, 32'h04030201, 8'd1);
        drain("t4");

        // 5: back-to-back frames
        do_reset();
        beat(1, 8'h11, NONE, 0, 0);
        beat(0, 8'h22, NONE, 0, 0);
        beat(0, 8'h33, NONE, 0, 0);
        beat(0, 8'h44, FRM, 32'h44332211, 8'd1);
        beat(1, 8'hC1, NONE, 0, 0);
        beat(0, 8'hC2, NONE, 0, 0);
        beat(0, 8'hC3, NONE, 0, 0);
        beat(0, 8'hC4, FRM, 32'hC4C3C2C1, 8'd2);
        drain("t5");
        chk("t5_ov_count", 64'(ov_cyc.size()), 64'd2);
        if (ov_cyc.size() == 2)
            chk("t5_ov_spacing", 64'(ov_cyc[1] - ov_cyc[0]), 64'd4);
        chk("t5_frame_cnt", {56'd0, bus.frame_cnt}, 64'd2);

        // 6: asynchronous reset mid-frame
        do_reset();
        beat(1, 8'h55, NONE, 0, 0);
        beat(0, 8'h56, NONE, 0, 0);
        beat(0, 8'h57, NONE, 0, 0);
        beat(0, 8'h58, FRM, 32'h58575655, 8'd1);
        idle(2);
        beat(1, 8'h61, NONE, 0, 0);
        beat(0, 8'h62, NONE, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_out_data", {32'd0, bus.out_data}, 64'd0);
        chk("t6_async_frame_cnt", {56'd0, bus.frame_cnt}, 64'd0);
        chk("t6_async_out_valid", {63'd0, bus.out_valid}, 64'd0);
        #2 rst_n = 1'b1;
        idle(1);
        ov_cyc.delete();
        beat(0, 8'h63, ERR, 0, 0);
        beat(0, 8'h64, ERR, 0, 0);
        drain("t6");
        chk("t6_ov_count", 64'(ov_cyc.size()), 64'd0);
        chk("t6_out_data", {32'd0, bus.out_data}, 64'd0);

        // 7: counter wrap after 256 frames
        do_reset();
        for (int i = 0; i < 256; i++) begin
            b0 = 8'(i); b1 = 8'(i + 1); b2 = 8'(i + 2); b3 = 8'(i + 3);
            beat(1, b0, NONE, 0, 0);
            beat(0, b1, NONE, 0, 0);
            beat(0, b2, NONE, 0, 0);
            beat(0, b3, FRM, {b3, b2, b1, b0}, 8'(i + 1));
        end
        drain("t7");
        chk("t7_wrap_cnt", {56'd0, bus.frame_cnt}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
